// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter (ALU vs. memory-load) with a busy-register scoreboard.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; default build gives the load port fixed priority.

module regfile_busy_cell (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic busy
);
    // A reservation landing on the same edge as the retiring write wins.
    always_ff @(posedge clk) begin
        if (reset)    busy <= 1'b0;
        else if (set) busy <= 1'b1;
        else if (clr) busy <= 1'b0;
    end
endmodule

module regfile_wb_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [2:0]       dest_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [2:0]       dest_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic [2:0]       DEST,
    output logic [WIDTH-1:0] w_in,
    output logic             w_en,
    input  logic             rsv_valid,
    input  logic [2:0]       rsv_dest,
    output logic             rsv_ready,
    input  logic [2:0]       SRC0,
    input  logic [2:0]       SRC1,
    output logic             stall
);
    typedef struct packed {
        logic [2:0]       dest;
        logic [WIDTH-1:0] data;
    } wb_req_t;

    wb_req_t    wb_a, wb_b, wb_sel;
    logic       elig_a, elig_b, gnt_a, gnt_b, gnt;
    logic [7:0] busy;
    logic [7:1] busy_set, busy_clr;

    assign wb_a = '{dest: dest_a, data: data_a};
    assign wb_b = '{dest: dest_b, data: data_b};

    // A request being acked this cycle was already consumed; it must not win again.
    assign elig_a = req_a & ~ack_a;
    assign elig_b = req_b & ~ack_b;

`ifdef REGFILE_ARB_RR_EN
    logic prefer_b;

    always_comb begin
        gnt_a = elig_a & (~elig_b | ~prefer_b);
        gnt_b = elig_b & ~gnt_a;
    end

    always_ff @(posedge clk) begin
        if (reset)      prefer_b <= 1'b0;
        else if (gnt_a) prefer_b <= 1'b1;
        else if (gnt_b) prefer_b <= 1'b0;
    end
`else
    always_comb begin
        gnt_b = elig_b;
        gnt_a = elig_a & ~elig_b;
    end
`endif

    assign gnt    = gnt_a | gnt_b;
    assign wb_sel = gnt_b ? wb_b : wb_a;

    // Writes to r0 are acknowledged but never reach the regfile.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            w_en  <= 1'b0;
            DEST  <= '0;
            w_in  <= '0;
        end else begin
            ack_a <= gnt_a;
            ack_b <= gnt_b;
            w_en  <= gnt & (wb_sel.dest != 3'd0);
            if (gnt) begin
                DEST <= wb_sel.dest;
                w_in <= wb_sel.data;
            end
        end
    end

    assign busy[0]   = 1'b0;
    assign rsv_ready = ~busy[rsv_dest];
    assign stall     = busy[SRC0] | busy[SRC1];

    for (genvar i = 1; i < 8; i++) begin : g_busy
        assign busy_set[i] = rsv_valid & rsv_ready & (rsv_dest == 3'(i));
        assign busy_clr[i] = gnt & (wb_sel.dest == 3'(i));

        regfile_busy_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .set   (busy_set[i]),
            .clr   (busy_clr[i]),
            .busy  (busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences, then random traffic vs. a reference model.
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_a, req_b, ack_a, ack_b, w_en;
    logic [2:0]       dest_a, dest_b, DEST;
    logic [WIDTH-1:0] data_a, data_b, w_in;
    logic             rsv_valid, rsv_ready, stall;
    logic [2:0]       rsv_dest, SRC0, SRC1;

    int checks = 0;
    int failures = 0;

    regfile_wb_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .dest_a(dest_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .dest_b(dest_b), .data_b(data_b), .ack_b(ack_b),
        .DEST(DEST), .w_in(w_in), .w_en(w_en),
        .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .rsv_ready(rsv_ready),
        .SRC0(SRC0), .SRC1(SRC1), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ra;
        logic [2:0]  da;
        logic [15:0] xa;
        logic        rb;
        logic [2:0]  db;
        logic [15:0] xb;
        logic        rv;
        logic [2:0]  rd, s0, s1;
        logic        e_ready, e_stall, e_acka, e_ackb, e_wen;
        logic [2:0]  e_dest;
        logic [15:0] e_win;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic rst, ra, input logic [2:0] da, input logic [15:0] xa,
                                input logic rb, input logic [2:0] db, input logic [15:0] xb,
                                input logic rv, input logic [2:0] rd, s0, s1,
                                input logic er, es, eaa, eab, ew, input logic [2:0] ed,
                                input logic [15:0] ewin);
        vec_t v;
        v.rst = rst; v.ra = ra; v.da = da; v.xa = xa; v.rb = rb; v.db = db; v.xb = xb;
        v.rv = rv; v.rd = rd; v.s0 = s0; v.s1 = s1;
        v.e_ready = er; v.e_stall = es; v.e_acka = eaa; v.e_ackb = eab; v.e_wen = ew;
        v.e_dest = ed; v.e_win = ewin;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, ra, input logic [2:0] da, input logic [15:0] xa,
                         input logic rb, input logic [2:0] db, input logic [15:0] xb,
                         input logic rv, input logic [2:0] rd, s0, s1);
        reset = rst; req_a = ra; dest_a = da; data_a = xa;
        req_b = rb; dest_b = db; data_b = xb;
        rsv_valid = rv; rsv_dest = rd; SRC0 = s0; SRC1 = s1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic        m_acka, m_ackb, m_wen;
    logic [2:0]  m_dest;
    logic [15:0] m_win;
    logic        m_busy[8];
`ifdef REGFILE_ARB_RR_EN
    logic        m_ptr_b;
`endif

    task automatic model_step();
        int   win;
        logic ea, eb, acc;
        logic [2:0] d;
        if (reset) begin
            m_acka = 0; m_ackb = 0; m_wen = 0; m_dest = 0; m_win = 0;
            foreach (m_busy[k]) m_busy[k] = 0;
`ifdef REGFILE_ARB_RR_EN
            m_ptr_b = 0;
`endif
        end else begin
            ea = req_a && !m_acka;
            eb = req_b && !m_ackb;
            if (ea && eb) begin
`ifdef REGFILE_ARB_RR_EN
                win = m_ptr_b ? 2 : 1;
`else
                win = 2;
`endif
            end else if (ea) win = 1;
            else if (eb) win = 2;
            else win = 0;
            acc = rsv_valid && !m_busy[rsv_dest] && rsv_dest != 0;
            m_wen = 0;
            if (win != 0) begin
                d = (win == 1) ? dest_a : dest_b;
                m_dest = d;
                m_win = (win == 1) ? data_a : data_b;
                m_wen = (d != 0);
                m_busy[d] = 0;
`ifdef REGFILE_ARB_RR_EN
                m_ptr_b = (win == 1);
`endif
            end
            if (acc) m_busy[rsv_dest] = 1;
            m_busy[0] = 0;
            m_acka = (win == 1);
            m_ackb = (win == 2);
        end
    endtask

    initial begin
        logic exp_a;
        logic a_act, b_act;
        logic [2:0] a_dest, b_dest;
        logic [15:0] a_data, b_data;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //           rst ra da xa       rb db xb       rv rd s0 s1 | rdy stl acka ackb wen dest win
        vt[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0000);
        vt[1]  = mk(0, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 1, 0, 1, 3, 16'h1234);
        vt[2]  = mk(0, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3, 16'h1234);
        vt[3]  = mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'hFFFF);
        vt[4]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0, 0,  1, 0, 0, 0, 0, 0, 16'hFFFF);
        vt[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 0,  0, 1, 0, 0, 0, 0, 16'hFFFF);
        vt[6]  = mk(0, 1, 5, 16'h0055, 0, 0, 16'h0000, 0, 5, 5, 0,  0, 1, 1, 0, 1, 5, 16'h0055);
        vt[7]  = mk(0, 1, 5, 16'h0055, 0, 0, 16'h0000, 0, 5, 5, 0,  1, 0, 0, 0, 0, 5, 16'h0055);
        vt[8]  = mk(0, 0, 0, 16'h0000, 1, 5, 16'hAAAA, 1, 5, 5, 0,  1, 0, 0, 1, 1, 5, 16'hAAAA);
        vt[9]  = mk(0, 0, 0, 16'h0000, 1, 5, 16'hAAAA, 0, 5, 0, 5,  0, 1, 0, 0, 0, 5, 16'hAAAA);
        vt[10] = mk(0, 1, 2, 16'h0202, 0, 0, 16'h0000, 0, 5, 0, 5,  0, 1, 1, 0, 1, 2, 16'h0202);
        vt[11] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2, 2, 5,  1, 1, 0, 0, 0, 2, 16'h0202);
        vt[12] = mk(1, 1, 6, 16'h0606, 0, 0, 16'h0000, 1, 3, 0, 5,  1, 1, 0, 0, 0, 0, 16'h0000);
        vt[13] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 3, 3, 5,  1, 0, 0, 0, 0, 0, 16'h0000);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rst, vt[i].ra, vt[i].da, vt[i].xa, vt[i].rb, vt[i].db, vt[i].xb,
                  vt[i].rv, vt[i].rd, vt[i].s0, vt[i].s1);
            #1;
            chk($sformatf("vec%0d rsv_ready", i), rsv_ready, vt[i].e_ready);
            chk($sformatf("vec%0d stall", i), stall, vt[i].e_stall);
            tick();
            chk($sformatf("vec%0d ack_a", i), ack_a, vt[i].e_acka);
            chk($sformatf("vec%0d ack_b", i), ack_b, vt[i].e_ackb);
            chk($sformatf("vec%0d w_en", i), w_en, vt[i].e_wen);
            chk($sformatf("vec%0d DEST", i), DEST, vt[i].e_dest);
            chk($sformatf("vec%0d w_in", i), w_in, vt[i].e_win);
        end

        // Both requesters held continuously: grants must alternate.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
`ifdef REGFILE_ARB_RR_EN
        exp_a = 1;
`else
        exp_a = 0;
`endif
        drive(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("alt%0d ack_a", i), ack_a, exp_a);
            chk($sformatf("alt%0d ack_b", i), ack_b, !exp_a);
            chk($sformatf("alt%0d w_in", i), w_in, exp_a ? 16'h1111 : 16'h2222);
            exp_a = !exp_a;
        end

        // Reset in the grant-decision cycle with a busy reg pending.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        drive(1, 1, 4, 16'h4444, 0, 0, 0, 0, 0, 4, 0);
        #1;
        chk("rst_dec stall_before", stall, 1);
        tick();
        chk("rst_dec ack_a", ack_a, 0);
        chk("rst_dec w_en", w_en, 0);
        drive(0, 1, 4, 16'h4444, 0, 0, 0, 0, 0, 4, 0);
        #1;
        chk("rst_dec busy_cleared", stall, 0);
        tick();
        chk("post_rst ack_a", ack_a, 1);
        chk("post_rst w_en", w_en, 1);
        chk("post_rst DEST", DEST, 4);
        chk("post_rst w_in", w_in, 16'h4444);

        // Randomized traffic against the reference model.
        a_act = 0; b_act = 0; a_dest = 0; b_dest = 0; a_data = 0; b_data = 0;
        m_acka = 0; m_ackb = 0;
        foreach (m_busy[k]) m_busy[k] = 0;
        for (int c = 0; c < 800; c++) begin
            logic r, rv;
            logic [2:0] rd, s0, s1;
            if (!a_act && $urandom_range(1, 0) == 1) begin
                a_act = 1; a_dest = 3'($urandom_range(7, 0)); a_data = 16'($urandom);
            end
            if (!b_act && $urandom_range(1, 0) == 1) begin
                b_act = 1; b_dest = 3'($urandom_range(7, 0)); b_data = 16'($urandom);
            end
            r  = (c == 0) || ($urandom_range(39, 0) == 0);
            rv = ($urandom_range(2, 0) == 0);
            rd = 3'($urandom_range(7, 0));
            s0 = 3'($urandom_range(7, 0));
            s1 = 3'($urandom_range(7, 0));
            drive(r, a_act, a_dest, a_data, b_act, b_dest, b_data, rv, rd, s0, s1);
            #1;
            if (c != 0) begin
                chk("rnd rsv_ready", rsv_ready, !m_busy[rd]);
                chk("rnd stall", stall, m_busy[s0] | m_busy[s1]);
            end
            model_step();
            tick();
            chk("rnd ack_a", ack_a, m_acka);
            chk("rnd ack_b", ack_b, m_ackb);
            chk("rnd w_en", w_en, m_wen);
            chk("rnd DEST", DEST, m_dest);
            chk("rnd w_in", w_in, m_win);
            if (m_acka) a_act = 0;
            if (m_ackb) b_act = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, data width of write path; SHALL match regfile word width.
REQ-002 Clock and reset SHALL be single clock, synchronous active-high reset, exactly so: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 Ports SHALL be:
 req_a  in  1  ALU writeback request; dest_a  in  3  target reg; data_a  in  WIDTH  write data; ack_a  out  1  write accepted.
 req_b  in  1  memory-load writeback request; dest_b  in  3; data_b  in  WIDTH; ack_b  out  1.
 DEST  out  3  regfile write address; w_in  out  WIDTH  regfile write data; w_en  out  1  regfile write enable.
 rsv_valid  in  1  issue stage reserves a dest; rsv_dest  in  3; rsv_ready  out  1  reservation acceptable.
 SRC0, SRC1  in  3  operand addresses of instruction at issue; stall  out  1  operand hazard.

Function
REQ-004 Requester SHALL hold req/dest/data stable until its ack; may drop or present a new request the cycle after ack.
REQ-005 Arbitration decision SHALL be made in cycle N from current req_a/req_b; DEST, w_in, w_en, ack_x SHALL be registered and valid in cycle N+1 (1-cycle latency).
REQ-006 A requester whose ack is high in the current cycle SHALL be excluded from that cycle's decision (no double grant of one held request).
REQ-007 At most one grant per cycle; ack_a and ack_b SHALL never be high together.
REQ-008 Both eligible: priority pointer selects winner; after any grant pointer SHALL point to the other requester; single eligible requester SHALL win regardless of pointer.
REQ-009 dest=0 (hardwired-zero reg): request SHALL be acked normally, w_en SHALL be 0 that cycle, DEST/w_in SHALL still carry the request values.
REQ-010 No grant: w_en=0, ack_a=ack_b=0, DEST/w_in SHALL hold previous values.
REQ-011 Scoreboard busy[7:1] (busy[0] constant 0): rsv_ready = !busy[rsv_dest] (combinational); rsv_ready=1 when rsv_dest=0.
REQ-012 rsv_valid & rsv_ready & rsv_dest!=0 SHALL set busy[rsv_dest] at clock edge; rsv_valid with rsv_ready=0 SHALL be ignored.
REQ-013 A grant to dest d!=0 in cycle N SHALL clear busy[d] at the edge ending cycle N (same edge w_en rises).
REQ-014 Same-edge set and clear of same dest SHALL leave busy set.
REQ-015 stall = busy[SRC0] | busy[SRC1], combinational; SRC=0 never stalls.
REQ-016 Grant to a non-busy dest SHALL proceed and leave busy unchanged.

Reset
REQ-017 reset high at an edge: ack_a, ack_b, w_en SHALL be 0; DEST=0; w_in=0; busy=0; pointer SHALL prefer A.
REQ-018 Requests present during reset SHALL be dropped without ack; a requester still asserting req after reset SHALL be arbitrated as new.
REQ-019 reset SHALL override any same-edge grant or reservation.

Configuration
REQ-020 Macro REGFILE_ARB_RR_EN defined: round-robin per REQ-008.
REQ-021 REGFILE_ARB_RR_EN undefined: fixed priority, B (memory) SHALL always win when both eligible; pointer logic absent; all other requirements unchanged.

Verification
REQ-022 After reset, req_a=1 dest_a=3 data_a=16'h1234 one cycle -> next cycle w_en=1, DEST=3, w_in=16'h1234, ack_a=1; following cycle w_en=0.
REQ-023 RR build, req_a and req_b held continuously (dest 1 and 2) -> grants alternate A,B,A,B; ack_a/ack_b never coincide; fixed-priority build -> B first, A granted only in cycle B is excluded.
REQ-024 req_b=1 dest_b=0 data_b=16'hFFFF -> ack_b=1, w_en=0, DEST=0.
REQ-025 rsv_valid=1 rsv_dest=5; next cycle SRC0=5 -> stall=1, rsv_ready for 5 =0; req_a dest_a=5 granted -> stall=0 in cycle w_en=1; same-edge rsv of 5 with grant to 5 -> busy[5] remains 1.
REQ-026 req_a held, busy[4]=1, reset asserted in grant-decision cycle -> no ack, w_en=0, busy=0; after reset deasserted, req_a acked one cycle later.
